// File: rtl/keypad_digit_entry_if.sv
// Keypad entry bundle: encoder inputs and the BCD digit outputs toward the timer/display stage.
// With DIGIT_LOCK_EN defined the bundle also carries o_overflow.
interface keypad_digit_entry_if;
  logic [3:0] i_d;
  logic       i_validn;
  logic       i_entry_en;
  logic       i_clear;
  logic [3:0] o_sec_ones;
  logic [3:0] o_sec_tens;
  logic [3:0] o_min_ones;
  logic [3:0] o_min_tens;
  logic       o_digit_strobe;
  logic [2:0] o_digit_count;
  logic       o_entry_nonzero;
`ifdef DIGIT_LOCK_EN
  logic       o_overflow;

  modport master (
    output i_d, i_validn, i_entry_en, i_clear,
    input  o_sec_ones, o_sec_tens, o_min_ones, o_min_tens,
    input  o_digit_strobe, o_digit_count, o_entry_nonzero, o_overflow
  );

  modport slave (
    input  i_d, i_validn, i_entry_en, i_clear,
    output o_sec_ones, o_sec_tens, o_min_ones, o_min_tens,
    output o_digit_strobe, o_digit_count, o_entry_nonzero, o_overflow
  );
`else
  modport master (
    output i_d, i_validn, i_entry_en, i_clear,
    input  o_sec_ones, o_sec_tens, o_min_ones, o_min_tens,
    input  o_digit_strobe, o_digit_count, o_entry_nonzero
  );

  modport slave (
    input  i_d, i_validn, i_entry_en, i_clear,
    output o_sec_ones, o_sec_tens, o_min_ones, o_min_tens,
    output o_digit_strobe, o_digit_count, o_entry_nonzero
  );
`endif
endinterface

// File: rtl/keypad_digit_entry.sv
// Debounced single-digit-per-press keypad entry shifting into a 4-digit BCD MM:SS register.
// Optional macro DIGIT_LOCK_EN: refuse digits once four are entered and flag o_overflow.
module keypad_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  keypad_digit_entry_if.slave   kp
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_DB     = 3'd1,
    ST_HELD         = 3'd2,
    ST_RELEASE_DB   = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_DB   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_ZERO = {CNT_W{1'b0}};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand;
  logic [3:0]       r_sec_ones;
  logic [3:0]       r_sec_tens;
  logic [3:0]       r_min_ones;
  logic [3:0]       r_min_tens;
  logic [2:0]       r_count;
  logic             r_strobe;

  logic w_accept;
  logic w_take;
  logic w_shift;

  // The accept event fires on the last stable PRESS_DB cycle, i.e. the cycle that moves to HELD.
  assign w_accept = (r_state == ST_PRESS_DB) && !kp.i_validn &&
                    (kp.i_d == r_cand) && (r_cnt == LP_DB);
  assign w_take   = w_accept && kp.i_entry_en && !kp.i_clear && (r_cand <= 4'd9);

`ifdef DIGIT_LOCK_EN
  logic r_overflow;
  logic w_full;
  assign w_full  = (r_count == 3'd4);
  assign w_shift = w_take && !w_full;
`else
  assign w_shift = w_take;
`endif

  // Press/release debounce FSM; reset parks it in WAIT_RELEASE so a held key is ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_WAIT_RELEASE;
      r_cnt   <= LP_ZERO;
      r_cand  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!kp.i_validn) begin
            r_state <= ST_PRESS_DB;
            r_cnt   <= LP_ONE;
            r_cand  <= kp.i_d;
          end
        end
        ST_PRESS_DB: begin
          if (kp.i_validn) begin
            r_state <= ST_IDLE;
            r_cnt   <= LP_ZERO;
          end else if (kp.i_d != r_cand) begin
            r_cand <= kp.i_d;
            r_cnt  <= LP_ONE;
          end else if (r_cnt == LP_DB) begin
            r_state <= ST_HELD;
            r_cnt   <= LP_ZERO;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        ST_HELD, ST_WAIT_RELEASE: begin
          if (kp.i_validn) begin
            r_state <= ST_RELEASE_DB;
            r_cnt   <= LP_ONE;
          end
        end
        ST_RELEASE_DB: begin
          if (!kp.i_validn) begin
            r_state <= ST_HELD;
            r_cnt   <= LP_ZERO;
          end else if (r_cnt == LP_DB) begin
            r_state <= ST_IDLE;
            r_cnt   <= LP_ZERO;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        default: begin
          r_state <= ST_WAIT_RELEASE;
          r_cnt   <= LP_ZERO;
        end
      endcase
    end
  end

  // Digit shift register, entry count and strobe; clear takes priority over a same-cycle accept.
  always_ff @(posedge i_clk) begin
    if (i_reset || kp.i_clear) begin
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_count    <= 3'd0;
      r_strobe   <= 1'b0;
    end else if (w_shift) begin
      r_min_tens <= r_min_ones;
      r_min_ones <= r_sec_tens;
      r_sec_tens <= r_sec_ones;
      r_sec_ones <= r_cand;
      r_strobe   <= 1'b1;
      if (r_count != 3'd4) begin
        r_count <= r_count + 3'd1;
      end
    end else begin
      r_strobe <= 1'b0;
    end
  end

`ifdef DIGIT_LOCK_EN
  // Sticky flag for a digit refused because the register is already full.
  always_ff @(posedge i_clk) begin
    if (i_reset || kp.i_clear) begin
      r_overflow <= 1'b0;
    end else if (w_take && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign kp.o_overflow = r_overflow;
`endif

  assign kp.o_sec_ones      = r_sec_ones;
  assign kp.o_sec_tens      = r_sec_tens;
  assign kp.o_min_ones      = r_min_ones;
  assign kp.o_min_tens      = r_min_tens;
  assign kp.o_digit_strobe  = r_strobe;
  assign kp.o_digit_count   = r_count;
  assign kp.o_entry_nonzero = |{r_sec_ones, r_sec_tens, r_min_ones, r_min_tens};

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry: run-length reference model plus directed and random presses.
module tb_keypad_digit_entry;
  localparam int DB = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_digit_entry_if kp();

  keypad_digit_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(5)) dut (
    .i_clk(clk),
    .i_reset(reset),
    .kp(kp)
  );

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a key is taken after DB+1 consecutive low samples of one code, and the
  // keypad re-arms only after DB+1 consecutive high samples.
  int m_dig[4];
  int m_count;
  bit m_strobe;
  bit m_ovf;
  bit m_armed;
  int m_low;
  int m_high;
  int m_cand;
  bit m_acc;
  bit m_valid = 1'b0;
`ifdef DIGIT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_count = 0; m_strobe = 0; m_ovf = 0;
        m_armed = 0; m_low = 0; m_high = 0; m_cand = 0;
        m_valid = 1;
      end else if (m_valid) begin
        m_acc = 0;
        if (m_armed) begin
          if (!kp.i_validn) begin
            if (m_low > 0 && int'(kp.i_d) == m_cand) m_low++;
            else begin m_cand = int'(kp.i_d); m_low = 1; end
            if (m_low == DB + 1) begin m_acc = 1; m_armed = 0; m_high = 0; end
          end else begin
            m_low = 0;
          end
        end else begin
          if (kp.i_validn) begin
            m_high++;
            if (m_high == DB + 1) begin m_armed = 1; m_low = 0; end
          end else begin
            m_high = 0;
          end
        end
        m_strobe = 0;
        if (kp.i_clear) begin
          for (int i = 0; i < 4; i++) m_dig[i] = 0;
          m_count = 0; m_ovf = 0;
        end else if (m_acc && kp.i_entry_en && m_cand <= 9) begin
          if (LOCK && m_count == 4) begin
            m_ovf = 1;
          end else begin
            for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i+1];
            m_dig[3] = m_cand;
            m_strobe = 1;
            if (m_count < 4) m_count++;
          end
        end
      end
    end
  end

  function automatic logic [15:0] dut_digits();
    return {kp.o_min_tens, kp.o_min_ones, kp.o_sec_tens, kp.o_sec_ones};
  endfunction

  function automatic logic dut_ovf();
`ifdef DIGIT_LOCK_EN
    return kp.o_overflow;
`else
    return 1'b0;
`endif
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [21:0] exp_v;
    logic [21:0] act_v;
    logic [15:0] exp_d;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        exp_d = {m_dig[0][3:0], m_dig[1][3:0], m_dig[2][3:0], m_dig[3][3:0]};
        exp_v = {exp_d, 3'(m_count), m_strobe, (exp_d != 16'd0), m_ovf};
        act_v = {dut_digits(), kp.o_digit_count, kp.o_digit_strobe, kp.o_entry_nonzero, dut_ovf()};
        check("outputs", 32'(act_v), 32'(exp_v));
        if (kp.o_digit_strobe) strobes++;
      end
    end
  end

  task automatic press(input logic [3:0] d, input int low, input int high, output int lat);
    kp.i_d = d;
    kp.i_validn = 1'b0;
    lat = 0;
    for (int k = 1; k <= low; k++) begin
      @(negedge clk);
      if (kp.o_digit_strobe && lat == 0) lat = k;
    end
    kp.i_validn = 1'b1;
    repeat (high) @(negedge clk);
  endtask

  initial begin
    int lat;
    int s0;
    logic [3:0] seq [4];
    reset = 1'b1;
    kp.i_d = 4'd5; kp.i_validn = 1'b0; kp.i_entry_en = 1'b1; kp.i_clear = 1'b0;
    repeat (3) @(negedge clk);

    // Key held through reset must never be taken.
    reset = 1'b0;
    repeat (40) @(negedge clk);
    kp.i_validn = 1'b1;
    repeat (30) @(negedge clk);
    check("reset_digits", 32'(dut_digits()), 32'h0);
    check("reset_count", 32'(kp.o_digit_count), 32'd0);
    check("reset_strobes", 32'(strobes), 32'd0);

    // Clean entry of 1,2,3,0 with latency check.
    seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd3; seq[3] = 4'd0;
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      press(seq[i], 25, 25, lat);
      check("latency", 32'(lat), 32'd21);
    end
    check("digits_1230", 32'(dut_digits()), 32'h1230);
    check("count_4", 32'(kp.o_digit_count), 32'd4);
    check("strobes_4", 32'(strobes - s0), 32'd4);

    // Fifth digit.
    press(4'd8, 25, 25, lat);
`ifdef DIGIT_LOCK_EN
    check("fifth_digits", 32'(dut_digits()), 32'h1230);
    check("fifth_overflow", 32'(dut_ovf()), 32'd1);
`else
    check("fifth_digits", 32'(dut_digits()), 32'h2308);
`endif
    check("fifth_count", 32'(kp.o_digit_count), 32'd4);

    kp.i_clear = 1'b1;
    @(negedge clk);
    kp.i_clear = 1'b0;
    @(negedge clk);
    check("clear_digits", 32'(dut_digits()), 32'h0);
    check("clear_count", 32'(kp.o_digit_count), 32'd0);

    // Press bounce on D=7.
    s0 = strobes;
    kp.i_d = 4'd7;
    for (int i = 0; i < 5; i++) begin
      kp.i_validn = 1'b0; repeat (3) @(negedge clk);
      kp.i_validn = 1'b1; repeat (3) @(negedge clk);
    end
    press(4'd7, 25, 25, lat);
    check("bounce_strobes", 32'(strobes - s0), 32'd1);
    check("bounce_sec_ones", 32'(kp.o_sec_ones), 32'd7);

    // Release bounce after 4.
    s0 = strobes;
    press(4'd4, 25, 3, lat);
    kp.i_validn = 1'b0; repeat (2) @(negedge clk);
    kp.i_validn = 1'b1; repeat (30) @(negedge clk);
    check("relbounce_strobes", 32'(strobes - s0), 32'd1);
    check("relbounce_count", 32'(kp.o_digit_count), 32'd2);
    check("relbounce_digits", 32'(dut_digits()), 32'h0074);

    // Clear coincident with accept of 9.
    s0 = strobes;
    kp.i_d = 4'd9; kp.i_validn = 1'b0;
    repeat (20) @(negedge clk);
    kp.i_clear = 1'b1;
    @(negedge clk);
    kp.i_clear = 1'b0;
    repeat (5) @(negedge clk);
    kp.i_validn = 1'b1;
    repeat (25) @(negedge clk);
    check("clracc_strobes", 32'(strobes - s0), 32'd0);
    check("clracc_digits", 32'(dut_digits()), 32'h0);
    check("clracc_count", 32'(kp.o_digit_count), 32'd0);

    // Entry disabled for a press of 6.
    s0 = strobes;
    kp.i_entry_en = 1'b0;
    press(4'd6, 25, 25, lat);
    kp.i_entry_en = 1'b1;
    check("disabled_strobes", 32'(strobes - s0), 32'd0);
    check("disabled_digits", 32'(dut_digits()), 32'h0);

    // Randomized presses, glitches, clears and enable changes.
    for (int seg = 0; seg < 150; seg++) begin
      int lo;
      int hi;
      lo = int'($urandom_range(1, 30));
      hi = int'($urandom_range(1, 30));
      kp.i_d = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
      kp.i_entry_en = ($urandom_range(0, 7) != 0);
      kp.i_validn = 1'b0;
      for (int k = 0; k < lo; k++) begin
        kp.i_clear = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 39) == 0) kp.i_d = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      kp.i_validn = 1'b1;
      for (int k = 0; k < hi; k++) begin
        kp.i_clear = ($urandom_range(0, 49) == 0);
        @(negedge clk);
      end
    end
    kp.i_clear = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
